mem_wb_pipe_reg: RTL and testbench

//  MEM/WB pipeline register of the 5-stage pipelined CPU. It sits between the

---
 rtl/mem_wb_pipe_reg.sv | 75 +++++++
 tb/tb_mem_wb_pipe_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: carries write-back controls, load data, ALU result
// and destination register index from the MEM stage to the WB stage.
// Latency: 1 cycle. There is no backpressure; the register captures every clock edge.
//
// Ports:
//   clk             pipeline clock, rising-edge active
//   startin         asynchronous active-low reset (0 = held in reset)
//   MEM_wb          WB control bundle from MEM: [1]=RegWrite, [0]=MemtoReg
//   MEM_mem_data    data read from data memory
//   MEM_alu_result  ALU result / memory address
//   MEM_mux_out     destination register index (RegDst mux output)
//   WB_reg_write    registered MEM_wb[1]
//   WB_mem_to_reg   registered MEM_wb[0]
//   WB_mem_data     registered MEM_mem_data
//   WB_alu_result   registered MEM_alu_result
//   WB_mux_out      registered MEM_mux_out
module mem_wb_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  startin,
  input  logic [1:0]            MEM_wb,
  input  logic [DATA_W-1:0]     MEM_mem_data,
  input  logic [DATA_W-1:0]     MEM_alu_result,
  input  logic [REG_ADDR_W-1:0] MEM_mux_out,
  output logic                  WB_reg_write,
  output logic                  WB_mem_to_reg,
  output logic [DATA_W-1:0]     WB_mem_data,
  output logic [DATA_W-1:0]     WB_alu_result,
  output logic [REG_ADDR_W-1:0] WB_mux_out
);

  logic                  reg_write_q,  reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [DATA_W-1:0]     mem_data_q,   mem_data_d;
  logic [DATA_W-1:0]     alu_result_q, alu_result_d;
  logic [REG_ADDR_W-1:0] mux_out_q,    mux_out_d;

  // No stall or flush: the next state is always the incoming MEM-stage values.
  // Control bits are copied verbatim, including the 2'b11 combination.
  always_comb begin
    reg_write_d  = MEM_wb[1];
    mem_to_reg_d = MEM_wb[0];
    mem_data_d   = MEM_mem_data;
    alu_result_d = MEM_alu_result;
    mux_out_d    = MEM_mux_out;
  end

  // Clearing everything on reset leaves a bubble in WB: RegWrite=0 means no
  // register file write happens while the pipeline is held or just released.
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      mux_out_q    <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_data_q   <= mem_data_d;
      alu_result_q <= alu_result_d;
      mux_out_q    <= mux_out_d;
    end
  end

  // Outputs come straight from flops; no input reaches an output combinationally.
  assign WB_reg_write  = reg_write_q;
  assign WB_mem_to_reg = mem_to_reg_q;
  assign WB_mem_data   = mem_data_q;
  assign WB_alu_result = alu_result_q;
  assign WB_mux_out    = mux_out_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for the MEM/WB pipeline register.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge
// or mid-cycle for the asynchronous reset checks.
module tb_mem_wb_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          startin;
  logic [1:0]    MEM_wb;
  logic [DW-1:0] MEM_mem_data;
  logic [DW-1:0] MEM_alu_result;
  logic [AW-1:0] MEM_mux_out;
  logic          WB_reg_write;
  logic          WB_mem_to_reg;
  logic [DW-1:0] WB_mem_data;
  logic [DW-1:0] WB_alu_result;
  logic [AW-1:0] WB_mux_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk            (clk),
    .startin        (startin),
    .MEM_wb         (MEM_wb),
    .MEM_mem_data   (MEM_mem_data),
    .MEM_alu_result (MEM_alu_result),
    .MEM_mux_out    (MEM_mux_out),
    .WB_reg_write   (WB_reg_write),
    .WB_mem_to_reg  (WB_mem_to_reg),
    .WB_mem_data    (WB_mem_data),
    .WB_alu_result  (WB_alu_result),
    .WB_mux_out     (WB_mux_out)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] wb, input logic [DW-1:0] md,
                           input logic [DW-1:0] alu, input logic [AW-1:0] dst);
    check({tag, ".reg_write"},  DW'(WB_reg_write),  DW'(wb[1]));
    check({tag, ".mem_to_reg"}, DW'(WB_mem_to_reg), DW'(wb[0]));
    check({tag, ".mem_data"},   WB_mem_data,        md);
    check({tag, ".alu_result"}, WB_alu_result,      alu);
    check({tag, ".mux_out"},    DW'(WB_mux_out),    DW'(dst));
  endtask

  task automatic drive(input logic [1:0] wb, input logic [DW-1:0] md,
                       input logic [DW-1:0] alu, input logic [AW-1:0] dst);
    MEM_wb         = wb;
    MEM_mem_data   = md;
    MEM_alu_result = alu;
    MEM_mux_out    = dst;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]    v_wb  [6];
  logic [DW-1:0] v_md  [6];
  logic [DW-1:0] v_alu [6];
  logic [AW-1:0] v_dst [6];

  initial begin
    // Back-to-back vector table.
    v_wb[0] = 2'b00; v_md[0] = 32'h0000_0001; v_alu[0] = 32'hFFFF_FFFE; v_dst[0] = 5'd0;
    v_wb[1] = 2'b11; v_md[1] = 32'h8000_0000; v_alu[1] = 32'h7FFF_FFFF; v_dst[1] = 5'd31;
    v_wb[2] = 2'b10; v_md[2] = 32'hDEAD_BEEF; v_alu[2] = 32'h1234_5678; v_dst[2] = 5'd17;
    v_wb[3] = 2'b01; v_md[3] = 32'hFFFF_FFFF; v_alu[3] = 32'h0000_0000; v_dst[3] = 5'd1;
    v_wb[4] = 2'b10; v_md[4] = 32'h5A5A_5A5A; v_alu[4] = 32'hA5A5_A5A5; v_dst[4] = 5'd10;
    v_wb[5] = 2'b00; v_md[5] = 32'hCAFE_F00D; v_alu[5] = 32'h0BAD_C0DE; v_dst[5] = 5'd21;

    startin = 1'b0;
    drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
    #1;
    check_all("reset_init", 2'b00, '0, '0, '0);

    // 1. Power-up: held in reset while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(2'(i), 32'h0101_0101 * (i + 1), 32'hF0F0_0000 + i, 5'(i * 9));
      edge_sample();
      check_all($sformatf("powerup%0d", i), 2'b00, '0, '0, '0);
    end

    // 2. Release reset mid-cycle, first capture at next edge.
    @(negedge clk);
    drive(2'b11, 32'h1111_1111, 32'hAABB_CCDD, 5'b11001);
    startin = 1'b1;
    edge_sample();
    check_all("release_cap", 2'b11, 32'h1111_1111, 32'hAABB_CCDD, 5'b11001);

    // 3. Asynchronous clear between edges.
    @(negedge clk);
    startin = 1'b0;
    #1;
    check_all("async_clear", 2'b00, '0, '0, '0);

    // 4. Inputs applied during reset are ignored until release.
    drive(2'b10, 32'h2222_2222, 32'hBBCC_DDEE, 5'b10101);
    edge_sample();
    check_all("held_reset", 2'b00, '0, '0, '0);
    @(negedge clk);
    startin = 1'b1;
    edge_sample();
    check_all("release2", 2'b10, 32'h2222_2222, 32'hBBCC_DDEE, 5'b10101);

    // 5. Mid-cycle input change must not show until the edge.
    @(negedge clk);
    drive(2'b01, 32'h3333_3333, 32'hCCDD_EEFF, 5'b01101);
    #1;
    check_all("hold_mid", 2'b10, 32'h2222_2222, 32'hBBCC_DDEE, 5'b10101);
    edge_sample();
    check_all("update", 2'b01, 32'h3333_3333, 32'hCCDD_EEFF, 5'b01101);

    // 6. Back-to-back: output tracks input delayed by one cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(v_wb[i], v_md[i], v_alu[i], v_dst[i]);
      #1;
      if (i > 0) check_all($sformatf("b2b_hold%0d", i), v_wb[i-1], v_md[i-1], v_alu[i-1], v_dst[i-1]);
      edge_sample();
      check_all($sformatf("b2b%0d", i), v_wb[i], v_md[i], v_alu[i], v_dst[i]);
    end

    // Reset mid-operation discards captured data.
    #2;
    startin = 1'b0;
    #1;
    check_all("mid_op_clear", 2'b00, '0, '0, '0);
    edge_sample();
    check_all("mid_op_held", 2'b00, '0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
